// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: takes a byte stream (word count, N big-endian words, checksum),
// writes each word to instruction memory and holds the CPU in reset until the image verifies.
module imem_loader #(
    parameter int IM_AW   = 8,
    parameter int TIMEOUT = 100000
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load_start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             im_we,
    output logic [IM_AW-1:0] im_addr,
    output logic [31:0]      im_wdata,
    output logic             cpu_resetn,
    output logic             busy,
    output logic             done,
    output logic [1:0]       error
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CSUM = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    localparam logic [1:0] E_NONE    = 2'd0;
    localparam logic [1:0] E_LENGTH  = 2'd1;
    localparam logic [1:0] E_CSUM    = 2'd2;
    localparam logic [1:0] E_TIMEOUT = 2'd3;

    localparam int              IW         = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0]   IDLE_LIMIT = IW'(TIMEOUT - 1);
    localparam logic [IW-1:0]   IDLE_ONE   = IW'(1);
    localparam logic [IM_AW:0]  CNT_ONE    = (IM_AW + 1)'(1);
    localparam logic [31:0]     MAX_WORDS  = 32'(2 ** IM_AW);

    logic [2:0]      state, next_state;
    logic [1:0]      byte_cnt;
    logic [23:0]     shift;
    logic [IM_AW:0]  word_cnt;
    logic [IM_AW:0]  n_words;
    logic [31:0]     checksum;
    logic [IW-1:0]   idle_cnt;

    logic            active;
    logic            accept;
    logic            word_full;
    logic            timed_out;
    logic            start;
    logic [31:0]     word;
    logic            next_done;
    logic [1:0]      next_error;

    assign active    = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
    assign in_ready  = active;
    assign busy      = active;
    assign accept    = in_valid && active;
    assign word_full = accept && (byte_cnt == 2'd3);
    assign word      = {shift, in_data};
    // An idle cycle at the limit is the TIMEOUT-th consecutive cycle without an accepted byte.
    assign timed_out = active && !accept && (idle_cnt == IDLE_LIMIT);
    assign start     = load_start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

    // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        next_state = state;
        next_done  = done;
        next_error = error;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    next_state = S_HDR;
                    next_done  = 1'b0;
                    next_error = E_NONE;
                end
            end
            S_HDR: begin
                if (timed_out) begin
                    next_state = S_ERR;
                    next_error = E_TIMEOUT;
                end else if (word_full) begin
                    if ((word == 32'd0) || (word > MAX_WORDS)) begin
                        next_state = S_ERR;
                        next_error = E_LENGTH;
                    end else begin
                        next_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (timed_out) begin
                    next_state = S_ERR;
                    next_error = E_TIMEOUT;
                end else if (word_full && ((word_cnt + CNT_ONE) == n_words)) begin
                    next_state = S_CSUM;
                end
            end
            S_CSUM: begin
                if (timed_out) begin
                    next_state = S_ERR;
                    next_error = E_TIMEOUT;
                end else if (word_full) begin
                    if (word == checksum) begin
                        next_state = S_DONE;
                        next_done  = 1'b1;
                    end else begin
                        next_state = S_ERR;
                        next_error = E_CSUM;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        // NOTE: every register is reset, including datapath, so a mid-session reset leaves no stale word.
        if (!resetn) begin
            state      <= S_IDLE;
            done       <= 1'b0;
            error      <= E_NONE;
            cpu_resetn <= 1'b0;
            im_we      <= 1'b0;
            im_addr    <= '0;
            im_wdata   <= '0;
            byte_cnt   <= 2'd0;
            shift      <= '0;
            word_cnt   <= '0;
            n_words    <= '0;
            checksum   <= '0;
            idle_cnt   <= '0;
        end else begin
            state      <= next_state;
            done       <= next_done;
            error      <= next_error;
            cpu_resetn <= (next_state == S_IDLE) || (next_state == S_DONE);
            im_we      <= 1'b0;

            if (start) begin
                byte_cnt <= 2'd0;
                word_cnt <= '0;
                checksum <= '0;
                idle_cnt <= '0;
            end else if (active) begin
                if (accept) begin
                    idle_cnt <= '0;
                    byte_cnt <= byte_cnt + 2'd1;
                    shift    <= {shift[15:0], in_data};
                end else begin
                    idle_cnt <= idle_cnt + IDLE_ONE;
                end
            end

            if ((state == S_HDR) && word_full) begin
                n_words <= word[IM_AW:0];
            end

            // Write strobe lands the cycle after the fourth byte of each data word.
            if ((state == S_DATA) && word_full) begin
                im_we    <= 1'b1;
                im_addr  <= word_cnt[IM_AW-1:0];
                im_wdata <= word;
                checksum <= checksum + word;
                word_cnt <= word_cnt + CNT_ONE;
            end
        end
    end

endmodule
